// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR file and trap controller:
// CSR addresses, csr_op encodings, interrupt cause codes and the
// mstatus / mie bit positions.
package csr_trap_unit_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // csr_op encodings
    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    // Interrupt cause codes (mcause[3:0] when mcause[31] is set)
    localparam logic [3:0] MCAUSE_MSI = 4'd3;
    localparam logic [3:0] MCAUSE_MTI = 4'd7;
    localparam logic [3:0] MCAUSE_MEI = 4'd11;

    // mstatus bit positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // mie / mip bit positions (match the cause codes)
    localparam int MIE_MSIE_BIT = 3;
    localparam int MIE_MTIE_BIT = 7;
    localparam int MIE_MEIE_BIT = 11;

    // Read-modify-write result of a CSR instruction on an old value.
    function automatic logic [31:0] csr_apply_op(input logic [1:0]  op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        logic [31:0] res;
        res = old_val;
        case (csr_op_e'(op))
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = old_val | wdata;
            CSR_OP_CLEAR: res = old_val & ~wdata;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with an increment enable and separate
// write ports for each 32-bit half. A write to either half wins over the
// increment for that cycle; the other half simply holds.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // Half-word writes take priority over the increment; wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 64'd0;
        end else if (wr_lo) begin
            count[31:0] <= wdata;
        end else if (wr_hi) begin
            count[63:32] <= wdata;
        end else if (inc_en) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller. Consumes the writeback
// stage's trap / mret reports, redirects fetch combinationally in the same
// cycle, masks the raw interrupt lines into eip/tip/sip, and services CSR
// reads and writes from execute.
//
// Event priority in a cycle: traped > mret > CSR write. A trap discards
// any coincident mret or CSR write. mret only competes with a CSR write
// for mstatus; other CSRs still take the write.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          HART_ID     = 0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_read_addr,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        csr_write,
    input  logic [11:0] csr_write_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    input  logic        retire,
    input  logic        traped,
    input  logic [3:0]  ecause,
    input  logic        interupt,
    input  logic [31:0] ecp,
    input  logic        mret,
    input  logic        meip_in,
    input  logic        mtip_in,
    input  logic        msip_in,
    output logic        eip,
    output logic        tip,
    output logic        sip,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    // Architectural state. mtvec bit1 and mepc bits1:0 are stored as zero.
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_msie;
    logic        mie_mtie;
    logic        mie_meie;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;

    logic        wr_en;
    logic        mret_en;
    logic [31:0] wr_old;
    logic [31:0] wr_val;
    logic [31:0] mtvec_base;

    assign mstatus_val = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
    assign mie_val     = {20'd0, mie_meie, 3'd0, mie_mtie, 3'd0, mie_msie, 3'd0};
    assign mip_val     = {20'd0, meip_in, 3'd0, mtip_in, 3'd0, msip_in, 3'd0};

    // Current architectural value of a CSR; unimplemented addresses read 0.
    function automatic logic [31:0] csr_value(input logic [11:0] addr);
        logic [31:0] v;
        v = 32'd0;
        case (addr)
            CSR_MSTATUS:   v = mstatus_val;
            CSR_MISA:      v = MISA_VALUE;
            CSR_MIE:       v = mie_val;
            CSR_MTVEC:     v = mtvec_q;
            CSR_MSCRATCH:  v = mscratch_q;
            CSR_MEPC:      v = mepc_q;
            CSR_MCAUSE:    v = mcause_q;
            CSR_MIP:       v = mip_val;
            CSR_MCYCLE:    v = mcycle_q[31:0];
            CSR_MCYCLEH:   v = mcycle_q[63:32];
            CSR_MINSTRET:  v = minstret_q[31:0];
            CSR_MINSTRETH: v = minstret_q[63:32];
            CSR_MHARTID:   v = 32'(HART_ID);
            default:       v = 32'd0;
        endcase
        return v;
    endfunction

    // True for any address outside the implemented set.
    function automatic logic csr_unimpl(input logic [11:0] addr);
        logic u;
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH,
            CSR_MINSTRET, CSR_MINSTRETH, CSR_MHARTID: u = 1'b0;
            default: u = 1'b1;
        endcase
        return u;
    endfunction

    // Execute-stage read port and the read-modify-write value for the write port.
    always_comb begin
        csr_rdata   = csr_value(csr_read_addr);
        csr_illegal = csr_unimpl(csr_read_addr);
        wr_old      = csr_value(csr_write_addr);
        wr_val      = csr_apply_op(csr_op, wr_old, csr_wdata);
    end

    assign wr_en   = csr_write && (csr_op != CSR_OP_NONE) && !traped;
    assign mret_en = mret && !traped;

    // Interrupt masking: global MIE gated with the per-source enables.
    assign eip = mstatus_mie & mie_meie & meip_in;
    assign tip = mstatus_mie & mie_mtie & mtip_in;
    assign sip = mstatus_mie & mie_msie & msip_in;

    // Same-cycle fetch redirect: vectored mode only offsets interrupts.
    assign mtvec_base = {mtvec_q[31:2], 2'b00};
    always_comb begin
        redirect    = traped | mret;
        redirect_pc = mepc_q;
        if (traped) begin
            if (mtvec_q[0] && interupt) begin
                redirect_pc = mtvec_base + {26'd0, ecause, 2'b00};
            end else begin
                redirect_pc = mtvec_base;
            end
        end
    end

    // mstatus interrupt-enable stack: trap pushes, mret pops, else CSR write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (traped) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_en) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_en && csr_write_addr == CSR_MSTATUS) begin
            mstatus_mie  <= wr_val[MSTATUS_MIE_BIT];
            mstatus_mpie <= wr_val[MSTATUS_MPIE_BIT];
        end
    end

    // Plain read/write CSRs: mie, mtvec, mscratch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_msie   <= 1'b0;
            mie_mtie   <= 1'b0;
            mie_meie   <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
            mscratch_q <= 32'd0;
        end else if (wr_en) begin
            case (csr_write_addr)
                CSR_MIE: begin
                    mie_msie <= wr_val[MIE_MSIE_BIT];
                    mie_mtie <= wr_val[MIE_MTIE_BIT];
                    mie_meie <= wr_val[MIE_MEIE_BIT];
                end
                CSR_MTVEC:    mtvec_q    <= {wr_val[31:2], 1'b0, wr_val[0]};
                CSR_MSCRATCH: mscratch_q <= wr_val;
                default: ;
            endcase
        end
    end

    // Trap record: mepc and mcause are captured on trap entry, else writable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
        end else if (traped) begin
            mepc_q   <= {ecp[31:2], 2'b00};
            mcause_q <= {interupt, 27'd0, ecause};
        end else if (wr_en && csr_write_addr == CSR_MEPC) begin
            mepc_q   <= {wr_val[31:2], 2'b00};
        end else if (wr_en && csr_write_addr == CSR_MCAUSE) begin
            mcause_q <= wr_val;
        end
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (1'b1),
        .wr_lo  (wr_en && csr_write_addr == CSR_MCYCLE),
        .wr_hi  (wr_en && csr_write_addr == CSR_MCYCLEH),
        .wdata  (wr_val),
        .count  (mcycle_q)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (retire && !traped),
        .wr_lo  (wr_en && csr_write_addr == CSR_MINSTRET),
        .wr_hi  (wr_en && csr_write_addr == CSR_MINSTRETH),
        .wdata  (wr_val),
        .count  (minstret_q)
    );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: reset state, CSR ops, interrupt
// masking, trap entry / mret redirect, event priority and counters.
module tb_csr_trap_unit;

    logic        clk;
    logic        rst_n;
    logic [11:0] csr_read_addr;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        csr_write;
    logic [11:0] csr_write_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        retire;
    logic        traped;
    logic [3:0]  ecause;
    logic        interupt;
    logic [31:0] ecp;
    logic        mret;
    logic        meip_in;
    logic        mtip_in;
    logic        msip_in;
    logic        eip;
    logic        tip;
    logic        sip;
    logic        redirect;
    logic [31:0] redirect_pc;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    csr_trap_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_read_addr  (csr_read_addr),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .csr_write      (csr_write),
        .csr_write_addr (csr_write_addr),
        .csr_op         (csr_op),
        .csr_wdata      (csr_wdata),
        .retire         (retire),
        .traped         (traped),
        .ecause         (ecause),
        .interupt       (interupt),
        .ecp            (ecp),
        .mret           (mret),
        .meip_in        (meip_in),
        .mtip_in        (mtip_in),
        .msip_in        (msip_in),
        .eip            (eip),
        .tip            (tip),
        .sip            (sip),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle CSR write command.
    task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_write      = 1'b1;
        csr_write_addr = a;
        csr_op         = op;
        csr_wdata      = d;
        tick();
        csr_write      = 1'b0;
        csr_op         = 2'b00;
        csr_wdata      = 32'd0;
    endtask

    // Put an address on the read port and let it settle.
    task automatic rd(input logic [11:0] a);
        csr_read_addr = a;
        #1;
    endtask

    task automatic clear_trap_inputs();
        traped   = 1'b0;
        interupt = 1'b0;
        ecause   = 4'd0;
        ecp      = 32'd0;
        mret     = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [8];
        logic [31:0] exps  [8];
        rst_n = 1'b0;
        meip_in = 1'b1; mtip_in = 1'b1; msip_in = 1'b1;
        tick(); tick();
        vec_cnt++;
        if (redirect !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reset_redirect: got %b expected 0", redirect);
        end
        vec_cnt++;
        if ({eip, tip, sip} !== 3'b000) begin
            miss_cnt++;
            $display("FAIL reset_irq: got %b expected 000", {eip, tip, sip});
        end
        meip_in = 1'b0; mtip_in = 1'b0; msip_in = 1'b0;
        rst_n = 1'b1;
        tick();
        // mstatus reads MPP=11 even out of reset
        addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14};
        exps  = '{32'h0000_1800, 32'h4000_0100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            rd(addrs[i]);
            vec_cnt++;
            if (csr_rdata !== exps[i] || csr_illegal !== 1'b0) begin
                miss_cnt++;
                $display("FAIL reset_read_%h: got %h ill=%b expected %h ill=0",
                         addrs[i], csr_rdata, csr_illegal, exps[i]);
            end
        end
        rd(12'h7C0);
        vec_cnt++;
        if (csr_rdata !== 32'd0 || csr_illegal !== 1'b1) begin
            miss_cnt++;
            $display("FAIL illegal_7c0: got %h ill=%b expected 0 ill=1", csr_rdata, csr_illegal);
        end
    endtask

    task automatic test_interrupt_trap();
        tick();
        csr_wr(12'h305, 2'b01, 32'h0000_0101);
        csr_wr(12'h304, 2'b01, 32'h0000_0800);
        csr_wr(12'h300, 2'b10, 32'h0000_0008);
        meip_in = 1'b1;
        #1;
        vec_cnt++;
        if ({eip, tip, sip} !== 3'b100) begin
            miss_cnt++;
            $display("FAIL eip_enabled: got %b expected 100", {eip, tip, sip});
        end
        rd(12'h344);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_0800) begin
            miss_cnt++;
            $display("FAIL mip_meip: got %h expected 00000800", csr_rdata);
        end
        traped = 1'b1; interupt = 1'b1; ecause = 4'd11; ecp = 32'h0000_0206;
        #1;
        vec_cnt++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h0000_012C) begin
            miss_cnt++;
            $display("FAIL irq_vector: got redir=%b pc=%h expected 1 0000012c", redirect, redirect_pc);
        end
        tick();
        clear_trap_inputs();
        #1;
        vec_cnt++;
        if (eip !== 1'b0) begin
            miss_cnt++;
            $display("FAIL eip_after_trap: got %b expected 0", eip);
        end
        rd(12'h341);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_0204) begin
            miss_cnt++;
            $display("FAIL mepc_irq: got %h expected 00000204", csr_rdata);
        end
        rd(12'h342);
        vec_cnt++;
        if (csr_rdata !== 32'h8000_000B) begin
            miss_cnt++;
            $display("FAIL mcause_irq: got %h expected 8000000b", csr_rdata);
        end
        rd(12'h300);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_1880) begin
            miss_cnt++;
            $display("FAIL mstatus_trap: got %h expected 00001880", csr_rdata);
        end
    endtask

    task automatic test_mret();
        tick();
        mret = 1'b1;
        #1;
        vec_cnt++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h0000_0204) begin
            miss_cnt++;
            $display("FAIL mret_redirect: got redir=%b pc=%h expected 1 00000204", redirect, redirect_pc);
        end
        tick();
        mret = 1'b0;
        #1;
        vec_cnt++;
        if (redirect !== 1'b0) begin
            miss_cnt++;
            $display("FAIL redirect_idle: got %b expected 0", redirect);
        end
        rd(12'h300);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_1888) begin
            miss_cnt++;
            $display("FAIL mstatus_mret: got %h expected 00001888", csr_rdata);
        end
        vec_cnt++;
        if (eip !== 1'b1) begin
            miss_cnt++;
            $display("FAIL eip_after_mret: got %b expected 1", eip);
        end
        meip_in = 1'b0;
    endtask

    task automatic test_csr_ops();
        tick();
        csr_wr(12'h304, 2'b01, 32'hFFFF_FFFF);
        rd(12'h304);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_0888) begin
            miss_cnt++;
            $display("FAIL mie_mask: got %h expected 00000888", csr_rdata);
        end
        mtip_in = 1'b1; msip_in = 1'b1;
        rd(12'h344);
        vec_cnt++;
        if ({eip, tip, sip} !== 3'b011 || csr_rdata !== 32'h0000_0088) begin
            miss_cnt++;
            $display("FAIL tip_sip: got irq=%b mip=%h expected 011 00000088", {eip, tip, sip}, csr_rdata);
        end
        mtip_in = 1'b0; msip_in = 1'b0;
        csr_wr(12'h304, 2'b01, 32'h0000_0800);
        csr_wr(12'h340, 2'b01, 32'h0000_1234);
        csr_wr(12'h340, 2'b10, 32'h0F00_0000);
        csr_wr(12'h340, 2'b11, 32'h0000_0004);
        csr_wr(12'h340, 2'b00, 32'hFFFF_FFFF);
        rd(12'h340);
        vec_cnt++;
        if (csr_rdata !== 32'h0F00_1230) begin
            miss_cnt++;
            $display("FAIL mscratch_rmw: got %h expected 0f001230", csr_rdata);
        end
        csr_wr(12'h341, 2'b01, 32'h0000_0123);
        rd(12'h341);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_0120) begin
            miss_cnt++;
            $display("FAIL mepc_align: got %h expected 00000120", csr_rdata);
        end
        csr_wr(12'h305, 2'b01, 32'h0000_0103);
        rd(12'h305);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_0101) begin
            miss_cnt++;
            $display("FAIL mtvec_bit1: got %h expected 00000101", csr_rdata);
        end
        csr_wr(12'h301, 2'b01, 32'h0000_0000);
        csr_wr(12'hF14, 2'b01, 32'h0000_0005);
        csr_wr(12'h7C0, 2'b01, 32'h0000_0005);
        rd(12'h301);
        vec_cnt++;
        if (csr_rdata !== 32'h4000_0100) begin
            miss_cnt++;
            $display("FAIL misa_ro: got %h expected 40000100", csr_rdata);
        end
        rd(12'hF14);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_0000) begin
            miss_cnt++;
            $display("FAIL mhartid_ro: got %h expected 00000000", csr_rdata);
        end
    endtask

    task automatic test_exception();
        tick();
        traped = 1'b1; interupt = 1'b0; ecause = 4'd2; ecp = 32'h0000_0300;
        #1;
        vec_cnt++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h0000_0100) begin
            miss_cnt++;
            $display("FAIL exc_base: got redir=%b pc=%h expected 1 00000100", redirect, redirect_pc);
        end
        tick();
        clear_trap_inputs();
        rd(12'h342);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_0002) begin
            miss_cnt++;
            $display("FAIL mcause_exc: got %h expected 00000002", csr_rdata);
        end
        rd(12'h300);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_1880) begin
            miss_cnt++;
            $display("FAIL mstatus_exc: got %h expected 00001880", csr_rdata);
        end
    endtask

    task automatic test_priority();
        // MIE=0, MPIE=1 here: an applied mret would set MIE.
        tick();
        traped = 1'b1; interupt = 1'b1; ecause = 4'd7; ecp = 32'h0000_0400;
        mret = 1'b1;
        csr_write = 1'b1; csr_write_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'h0000_DEAD;
        #1;
        vec_cnt++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h0000_011C) begin
            miss_cnt++;
            $display("FAIL prio_redirect: got redir=%b pc=%h expected 1 0000011c", redirect, redirect_pc);
        end
        tick();
        clear_trap_inputs();
        csr_write = 1'b0; csr_op = 2'b00; csr_wdata = 32'd0;
        rd(12'h340);
        vec_cnt++;
        if (csr_rdata !== 32'h0F00_1230) begin
            miss_cnt++;
            $display("FAIL prio_mscratch: got %h expected 0f001230", csr_rdata);
        end
        rd(12'h300);
        vec_cnt++;
        if (csr_rdata !== 32'h0000_1800) begin
            miss_cnt++;
            $display("FAIL prio_mstatus: got %h expected 00001800", csr_rdata);
        end
        rd(12'h342);
        vec_cnt++;
        if (csr_rdata !== 32'h8000_0007) begin
            miss_cnt++;
            $display("FAIL prio_mcause: got %h expected 80000007", csr_rdata);
        end
    endtask

    task automatic test_counters();
        tick();
        csr_wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        csr_wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
        tick();
        rd(12'hB00);
        vec_cnt++;
        if (csr_rdata !== 32'd0) begin
            miss_cnt++;
            $display("FAIL mcycle_wrap_lo: got %h expected 00000000", csr_rdata);
        end
        rd(12'hB80);
        vec_cnt++;
        if (csr_rdata !== 32'd0) begin
            miss_cnt++;
            $display("FAIL mcycle_wrap_hi: got %h expected 00000000", csr_rdata);
        end
        // minstret: three retire cycles, one of them trapping
        csr_wr(12'hB02, 2'b01, 32'd0);
        csr_wr(12'hB82, 2'b01, 32'd0);
        retire = 1'b1;
        tick();
        traped = 1'b1; ecause = 4'd2; ecp = 32'h0000_0500;
        tick();
        clear_trap_inputs();
        tick();
        retire = 1'b0;
        rd(12'hB02);
        vec_cnt++;
        if (csr_rdata !== 32'd2 || csr_illegal !== 1'b0) begin
            miss_cnt++;
            $display("FAIL minstret_count: got %h ill=%b expected 00000002 ill=0", csr_rdata, csr_illegal);
        end
        // A write to minstret replaces that cycle's increment
        retire = 1'b1;
        csr_wr(12'hB02, 2'b01, 32'd5);
        retire = 1'b0;
        rd(12'hB02);
        vec_cnt++;
        if (csr_rdata !== 32'd5) begin
            miss_cnt++;
            $display("FAIL minstret_write_wins: got %h expected 00000005", csr_rdata);
        end
        // Wrap at 2^64-1
        csr_wr(12'hB02, 2'b01, 32'hFFFF_FFFF);
        csr_wr(12'hB82, 2'b01, 32'hFFFF_FFFF);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        rd(12'hB02);
        vec_cnt++;
        if (csr_rdata !== 32'd0) begin
            miss_cnt++;
            $display("FAIL minstret_wrap_lo: got %h expected 00000000", csr_rdata);
        end
        rd(12'hB82);
        vec_cnt++;
        if (csr_rdata !== 32'd0) begin
            miss_cnt++;
            $display("FAIL minstret_wrap_hi: got %h expected 00000000", csr_rdata);
        end
    endtask

    // Hard time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, expected finish before 200000ns");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        csr_read_addr = 12'd0;
        csr_write = 1'b0; csr_write_addr = 12'd0; csr_op = 2'b00; csr_wdata = 32'd0;
        retire = 1'b0;
        meip_in = 1'b0; mtip_in = 1'b0; msip_in = 1'b0;
        clear_trap_inputs();
        test_reset();
        test_interrupt_trap();
        test_mret();
        test_csr_ops();
        test_exception();
        test_priority();
        test_counters();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
